// File: rtl/sdram_client_arbiter_if.sv
// Bundle of the client ports (CPU, video) and the SDRAM controller request port
// around sdram_client_arbiter. The arbiter uses the slave view; the surroundings use master.
interface sdram_client_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be_n;
    logic [15:0] cpu_rdata;
    logic        cpu_done;

    logic        vid_req;
    logic [21:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        vid_done;

    logic [21:0] mem_addr;
    logic [15:0] mem_dataw;
    logic        mem_rd;
    logic        mem_we_n;
    logic        mem_lb_n;
    logic        mem_ub_n;
    logic        mem_refresh;
    logic [15:0] mem_datar;
    logic        mem_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_n,
        output cpu_rdata, cpu_done,
        input  vid_req, vid_addr,
        output vid_rdata, vid_done,
        output mem_addr, mem_dataw, mem_rd, mem_we_n, mem_lb_n, mem_ub_n, mem_refresh,
        input  mem_datar, mem_busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_n,
        input  cpu_rdata, cpu_done,
        output vid_req, vid_addr,
        input  vid_rdata, vid_done,
        input  mem_addr, mem_dataw, mem_rd, mem_we_n, mem_lb_n, mem_ub_n, mem_refresh,
        output mem_datar, mem_busy
    );
endinterface

// File: rtl/sdram_client_arbiter.sv
// Arbitrates refresh, video reads and CPU accesses onto the single SDRAM controller
// request port, sequencing each transaction through the controller's busy handshake.
module sdram_client_arbiter #(
    parameter int REFRESH_PERIOD = 1200
) (
    input logic                   clk,
    input logic                   reset,
    sdram_client_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAITHI,
        S_WAITLO
    } state_t;

    typedef enum logic [1:0] {
        OWN_REF,
        OWN_VID,
        OWN_CPU
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             is_read_q, is_read_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_pending_q, ref_pending_d;

    logic [21:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_dataw_q, mem_dataw_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_we_n_q, mem_we_n_d;
    logic             mem_lb_n_q, mem_lb_n_d;
    logic             mem_ub_n_q, mem_ub_n_d;
    logic             mem_refresh_q, mem_refresh_d;

    logic [15:0]      cpu_rdata_q, cpu_rdata_d;
    logic             cpu_done_q, cpu_done_d;
    logic [15:0]      vid_rdata_q, vid_rdata_d;
    logic             vid_done_q, vid_done_d;

    // A requester still holds req in its done cycle, so that cycle must not re-grant it.
    logic vid_grantable;
    logic cpu_grantable;

    assign vid_grantable = bus.vid_req && !vid_done_q;
    assign cpu_grantable = bus.cpu_req && !cpu_done_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        is_read_d     = is_read_q;
        wait_cnt_d    = wait_cnt_q;
        ref_cnt_d     = ref_cnt_q - CNT_W'(1);
        ref_pending_d = ref_pending_q;
        mem_addr_d    = mem_addr_q;
        mem_dataw_d   = mem_dataw_q;
        mem_rd_d      = mem_rd_q;
        mem_we_n_d    = mem_we_n_q;
        mem_lb_n_d    = mem_lb_n_q;
        mem_ub_n_d    = mem_ub_n_q;
        mem_refresh_d = mem_refresh_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_done_d    = 1'b0;
        vid_rdata_d   = vid_rdata_q;
        vid_done_d    = 1'b0;

        // An expiry while a refresh is already pending is simply absorbed.
        if (ref_cnt_q == '0) begin
            ref_cnt_d     = RELOAD;
            ref_pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    owner_d       = OWN_REF;
                    is_read_d     = 1'b0;
                    mem_refresh_d = 1'b1;
                    ref_pending_d = 1'b0;
                    state_d       = S_ISSUE;
                end else if (vid_grantable) begin
                    owner_d    = OWN_VID;
                    is_read_d  = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = bus.vid_addr;
                    mem_lb_n_d = 1'b0;
                    mem_ub_n_d = 1'b0;
                    state_d    = S_ISSUE;
                end else if (cpu_grantable) begin
                    owner_d     = OWN_CPU;
                    is_read_d   = !bus.cpu_we;
                    mem_rd_d    = !bus.cpu_we;
                    mem_we_n_d  = !bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_dataw_d = bus.cpu_wdata;
                    mem_lb_n_d  = bus.cpu_be_n[0];
                    mem_ub_n_d  = bus.cpu_be_n[1];
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mem_rd_d      = 1'b0;
                mem_we_n_d    = 1'b1;
                mem_refresh_d = 1'b0;
                wait_cnt_d    = 2'd0;
                state_d       = S_WAITHI;
            end

            S_WAITHI: begin
                if (bus.mem_busy) begin
                    state_d = S_WAITLO;
                end else if (wait_cnt_q == 2'd2) begin
                    // Controller never acknowledged: client requests are still held,
                    // but a refresh has to be put back in the queue explicitly.
                    state_d = S_IDLE;
                    if (owner_q == OWN_REF) begin
                        ref_pending_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            S_WAITLO: begin
                if (!bus.mem_busy) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_VID) begin
                        vid_done_d  = 1'b1;
                        vid_rdata_d = bus.mem_datar;
                    end else if (owner_q == OWN_CPU) begin
                        cpu_done_d = 1'b1;
                        if (is_read_q) begin
                            cpu_rdata_d = bus.mem_datar;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_REF;
            is_read_q     <= 1'b0;
            wait_cnt_q    <= 2'd0;
            ref_cnt_q     <= RELOAD;
            ref_pending_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_dataw_q   <= '0;
            mem_rd_q      <= 1'b0;
            mem_we_n_q    <= 1'b1;
            mem_lb_n_q    <= 1'b1;
            mem_ub_n_q    <= 1'b1;
            mem_refresh_q <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_done_q    <= 1'b0;
            vid_rdata_q   <= '0;
            vid_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            is_read_q     <= is_read_d;
            wait_cnt_q    <= wait_cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            mem_addr_q    <= mem_addr_d;
            mem_dataw_q   <= mem_dataw_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_n_q    <= mem_we_n_d;
            mem_lb_n_q    <= mem_lb_n_d;
            mem_ub_n_q    <= mem_ub_n_d;
            mem_refresh_q <= mem_refresh_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_done_q    <= cpu_done_d;
            vid_rdata_q   <= vid_rdata_d;
            vid_done_q    <= vid_done_d;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_dataw   = mem_dataw_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_we_n    = mem_we_n_q;
    assign bus.mem_lb_n    = mem_lb_n_q;
    assign bus.mem_ub_n    = mem_ub_n_q;
    assign bus.mem_refresh = mem_refresh_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_done    = cpu_done_q;
    assign bus.vid_rdata   = vid_rdata_q;
    assign bus.vid_done    = vid_done_q;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter with a small behavioural SDRAM controller
// model; cycle 0 of each scenario is the cycle in which the request is first presented.
module tb_sdram_client_arbiter;

    localparam int PERIOD = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic        model_mute = 1'b0;
    logic [15:0] model_rdata = 16'h0000;
    int          remain;
    logic        ref_prev;

    sdram_client_arbiter_if bus();

    sdram_client_arbiter #(.REFRESH_PERIOD(PERIOD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises after the strobe, stays high 6 cycles for a
    // read/write and 9 for a refresh; muting it emulates a controller that never answers.
    always @(posedge clk) begin
        if (reset) begin
            bus.mem_busy  <= 1'b0;
            bus.mem_datar <= 16'h0000;
            remain        <= 0;
            ref_prev      <= 1'b0;
        end else begin
            ref_prev <= bus.mem_refresh;
            if (!model_mute && (bus.mem_rd || !bus.mem_we_n)) begin
                bus.mem_busy <= 1'b1;
                remain       <= 5;
                if (bus.mem_rd) bus.mem_datar <= model_rdata;
            end else if (!model_mute && bus.mem_refresh && !ref_prev) begin
                bus.mem_busy <= 1'b1;
                remain       <= 8;
            end else if (remain > 0) begin
                remain <= remain - 1;
            end else begin
                bus.mem_busy <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vreq, input logic [21:0] vaddr, input logic creq,
                                 input logic cwe, input logic [21:0] caddr,
                                 input logic [15:0] cwdata, input logic [1:0] cbe_n);
        bus.vid_req   = vreq;
        bus.vid_addr  = vaddr;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwdata;
        bus.cpu_be_n  = cbe_n;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench in the first cycle out of reset, with the refresh timer at its reload value.
    task automatic resetDut();
        reset = 1'b1;
        model_mute = 1'b0;
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);
        step(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.mem_refresh) begin
            checkOutput("refresh_exclusive", 32'(bus.mem_rd || !bus.mem_we_n), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);

        // Reset values
        resetDut();
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        checkOutput("rst_mem_refresh", 32'(bus.mem_refresh), 32'h0);
        checkOutput("rst_cpu_done", 32'(bus.cpu_done), 32'h0);
        checkOutput("rst_vid_done", 32'(bus.vid_done), 32'h0);
        checkOutput("rst_mem_we_n", 32'(bus.mem_we_n), 32'h1);
        checkOutput("rst_mem_lb_n", 32'(bus.mem_lb_n), 32'h1);
        checkOutput("rst_mem_ub_n", 32'(bus.mem_ub_n), 32'h1);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("rst_mem_dataw", 32'(bus.mem_dataw), 32'h0);
        checkOutput("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        checkOutput("rst_vid_rdata", 32'(bus.vid_rdata), 32'h0);

        // CPU read
        model_rdata = 16'hBEEF;
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h12345, 16'h0, 2'b00);
        step(1);
        checkOutput("rd_strobe_c1", 32'(bus.mem_rd), 32'h1);
        checkOutput("rd_addr_c1", 32'(bus.mem_addr), 32'h12345);
        checkOutput("rd_we_n_c1", 32'(bus.mem_we_n), 32'h1);
        step(1);
        checkOutput("rd_strobe_c2", 32'(bus.mem_rd), 32'h0);
        step(6);
        checkOutput("rd_done_c8", 32'(bus.cpu_done), 32'h0);
        step(1);
        checkOutput("rd_done_c9", 32'(bus.cpu_done), 32'h1);
        checkOutput("rd_data_c9", 32'(bus.cpu_rdata), 32'hBEEF);
        step(1);
        checkOutput("rd_done_c10", 32'(bus.cpu_done), 32'h0);
        checkOutput("rd_no_regrant_c10", 32'(bus.mem_rd), 32'h0);
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);
        step(1);
        checkOutput("rd_no_regrant_c11", 32'(bus.mem_rd), 32'h0);

        // CPU write, upper byte masked, top of address space
        resetDut();
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b1, 22'h3FFFFF, 16'hA55A, 2'b10);
        step(1);
        checkOutput("wr_we_n_c1", 32'(bus.mem_we_n), 32'h0);
        checkOutput("wr_rd_c1", 32'(bus.mem_rd), 32'h0);
        checkOutput("wr_lb_n_c1", 32'(bus.mem_lb_n), 32'h0);
        checkOutput("wr_ub_n_c1", 32'(bus.mem_ub_n), 32'h1);
        checkOutput("wr_dataw_c1", 32'(bus.mem_dataw), 32'hA55A);
        checkOutput("wr_addr_c1", 32'(bus.mem_addr), 32'h3FFFFF);
        step(1);
        checkOutput("wr_we_n_c2", 32'(bus.mem_we_n), 32'h1);
        checkOutput("wr_dataw_hold_c2", 32'(bus.mem_dataw), 32'hA55A);
        step(7);
        checkOutput("wr_done_c9", 32'(bus.cpu_done), 32'h1);
        checkOutput("wr_rdata_kept_c9", 32'(bus.cpu_rdata), 32'h0);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);

        // Simultaneous video and CPU requests: video wins
        resetDut();
        model_rdata = 16'h1234;
        applyStimulus(1'b1, 22'h0F0F0, 1'b1, 1'b0, 22'h00055, 16'h0, 2'b01);
        step(1);
        checkOutput("sim_vid_strobe_c1", 32'(bus.mem_rd), 32'h1);
        checkOutput("sim_vid_addr_c1", 32'(bus.mem_addr), 32'h0F0F0);
        checkOutput("sim_vid_lb_n_c1", 32'(bus.mem_lb_n), 32'h0);
        checkOutput("sim_vid_ub_n_c1", 32'(bus.mem_ub_n), 32'h0);
        step(1);
        model_rdata = 16'h5678;
        step(7);
        checkOutput("sim_vid_done_c9", 32'(bus.vid_done), 32'h1);
        checkOutput("sim_vid_data_c9", 32'(bus.vid_rdata), 32'h1234);
        checkOutput("sim_cpu_done_c9", 32'(bus.cpu_done), 32'h0);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h00055, 16'h0, 2'b01);
        checkOutput("sim_cpu_strobe_c10", 32'(bus.mem_rd), 32'h1);
        checkOutput("sim_cpu_addr_c10", 32'(bus.mem_addr), 32'h00055);
        checkOutput("sim_cpu_lb_n_c10", 32'(bus.mem_lb_n), 32'h1);
        checkOutput("sim_cpu_ub_n_c10", 32'(bus.mem_ub_n), 32'h0);
        checkOutput("sim_vid_done_c10", 32'(bus.vid_done), 32'h0);
        step(8);
        checkOutput("sim_cpu_done_c18", 32'(bus.cpu_done), 32'h1);
        checkOutput("sim_cpu_data_c18", 32'(bus.cpu_rdata), 32'h5678);
        checkOutput("sim_vid_data_c18", 32'(bus.vid_rdata), 32'h1234);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);

        // Refresh expiring (cycle 64 after reset) during a video read with a CPU write queued
        resetDut();
        step(58);
        model_rdata = 16'hCAFE;
        applyStimulus(1'b1, 22'h00100, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);
        step(2);
        applyStimulus(1'b1, 22'h00100, 1'b1, 1'b1, 22'h00200, 16'h0F0F, 2'b00);
        step(4);
        checkOutput("ref_held_c64", 32'(bus.mem_refresh), 32'h0);
        step(3);
        checkOutput("ref_vid_done_c67", 32'(bus.vid_done), 32'h1);
        checkOutput("ref_vid_data_c67", 32'(bus.vid_rdata), 32'hCAFE);
        checkOutput("ref_not_yet_c67", 32'(bus.mem_refresh), 32'h0);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b1, 22'h00200, 16'h0F0F, 2'b00);
        checkOutput("ref_strobe_c68", 32'(bus.mem_refresh), 32'h1);
        checkOutput("ref_we_n_c68", 32'(bus.mem_we_n), 32'h1);
        step(1);
        checkOutput("ref_strobe_c69", 32'(bus.mem_refresh), 32'h0);
        step(10);
        checkOutput("ref_cpu_wait_c79", 32'(bus.mem_we_n), 32'h1);
        step(1);
        checkOutput("ref_cpu_strobe_c80", 32'(bus.mem_we_n), 32'h0);
        checkOutput("ref_cpu_dataw_c80", 32'(bus.mem_dataw), 32'h0F0F);
        step(8);
        checkOutput("ref_cpu_done_c88", 32'(bus.cpu_done), 32'h1);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);

        // Busy timeout: controller silent for the first issue
        resetDut();
        model_mute = 1'b1;
        model_rdata = 16'h7E57;
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h00ABC, 16'h0, 2'b00);
        step(1);
        checkOutput("to_strobe_c1", 32'(bus.mem_rd), 32'h1);
        step(1);
        checkOutput("to_strobe_c2", 32'(bus.mem_rd), 32'h0);
        step(3);
        checkOutput("to_strobe_c5", 32'(bus.mem_rd), 32'h0);
        checkOutput("to_done_c5", 32'(bus.cpu_done), 32'h0);
        step(1);
        model_mute = 1'b0;
        checkOutput("to_reissue_c6", 32'(bus.mem_rd), 32'h1);
        checkOutput("to_reissue_addr_c6", 32'(bus.mem_addr), 32'h00ABC);
        step(7);
        checkOutput("to_done_c13", 32'(bus.cpu_done), 32'h0);
        step(1);
        checkOutput("to_done_c14", 32'(bus.cpu_done), 32'h1);
        checkOutput("to_data_c14", 32'(bus.cpu_rdata), 32'h7E57);
        step(1);
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);

        // Reset in the cycle busy falls: no done pulse, timer restarts
        resetDut();
        model_rdata = 16'h1111;
        applyStimulus(1'b0, 22'h0, 1'b1, 1'b0, 22'h2AAAA, 16'h0, 2'b00);
        step(8);
        checkOutput("mr_done_c8", 32'(bus.cpu_done), 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11);
        step(1);
        reset = 1'b0;
        checkOutput("mr_cpu_done", 32'(bus.cpu_done), 32'h0);
        checkOutput("mr_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        checkOutput("mr_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkOutput("mr_mem_rd", 32'(bus.mem_rd), 32'h0);
        checkOutput("mr_mem_we_n", 32'(bus.mem_we_n), 32'h1);
        checkOutput("mr_mem_lb_n", 32'(bus.mem_lb_n), 32'h1);
        step(64);
        checkOutput("mr_refresh_before", 32'(bus.mem_refresh), 32'h0);
        step(1);
        checkOutput("mr_refresh_at", 32'(bus.mem_refresh), 32'h1);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
